// File: rtl/memory_dp_be_if.sv
// Bus bundle for the dual-port byte-enable RAM: two independent access ports
// plus the clear-engine busy flag.
interface memory_dp_be_if #(
  parameter int ADD_WIDTH = 10,
  parameter int DAT_WIDTH = 32
);
  localparam int unsigned NUM_BE = DAT_WIDTH / 8;

  logic                 busy;

  logic                 a_en;
  logic [NUM_BE-1:0]    a_we;
  logic [ADD_WIDTH-1:0] a_add;
  logic [DAT_WIDTH-1:0] a_din;
  logic [DAT_WIDTH-1:0] a_dout;
  logic                 a_valid;

  logic                 b_en;
  logic [NUM_BE-1:0]    b_we;
  logic [ADD_WIDTH-1:0] b_add;
  logic [DAT_WIDTH-1:0] b_din;
  logic [DAT_WIDTH-1:0] b_dout;
  logic                 b_valid;

  modport master (
    input  busy,
    output a_en, a_we, a_add, a_din,
    input  a_dout, a_valid,
    output b_en, b_we, b_add, b_din,
    input  b_dout, b_valid
  );

  modport slave (
    output busy,
    input  a_en, a_we, a_add, a_din,
    output a_dout, a_valid,
    input  b_en, b_we, b_add, b_din,
    output b_dout, b_valid
  );
endinterface

// File: rtl/memory_dp_be.sv
// Dual-port synchronous RAM with byte-lane writes, selectable same-port
// read-during-write behaviour, optional output register and a zero-fill engine.
module memory_dp_be #(
  parameter int ADD_WIDTH = 10,
  parameter int DAT_WIDTH = 32,
  parameter int RDW_MODE  = 0,
  parameter int OUT_REG   = 0
) (
  input  logic           clk,
  input  logic           rst,
  memory_dp_be_if.slave  bus
);
  localparam int unsigned NUM_BE = DAT_WIDTH / 8;
  localparam int unsigned DEPTH  = 1 << ADD_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e               state_q;
  logic [ADD_WIDTH-1:0] ptr_q;
  logic                 busy_q;

  logic [DAT_WIDTH-1:0] mem_q [DEPTH];

  logic                 en       [2];
  logic [NUM_BE-1:0]    we       [2];
  logic [ADD_WIDTH-1:0] add      [2];
  logic [DAT_WIDTH-1:0] din      [2];
  logic [DAT_WIDTH-1:0] old_w    [2];
  logic [DAT_WIDTH-1:0] merged_w [2];

  logic [DAT_WIDTH-1:0] dout1_q  [2];
  logic                 valid1_q [2];
  logic [DAT_WIDTH-1:0] dout2_q  [2];
  logic                 valid2_q [2];

  logic                 access_ok;

  always_comb begin
    en[0]  = bus.a_en;
    we[0]  = bus.a_we;
    add[0] = bus.a_add;
    din[0] = bus.a_din;
    en[1]  = bus.b_en;
    we[1]  = bus.b_we;
    add[1] = bus.b_add;
    din[1] = bus.b_din;
  end

  // A write coinciding with a reset edge must not land, even if busy_q was low.
  assign access_ok = !rst && !busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + ADD_WIDTH'(1);
          if (&ptr_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      old_w[p]    = mem_q[add[p]];
      merged_w[p] = old_w[p];
      for (int unsigned i = 0; i < NUM_BE; i++) begin
        if (we[p][i]) merged_w[p][8*i +: 8] = din[p][8*i +: 8];
      end
    end
  end

  // Port B lanes are assigned first so that port A wins on shared address/lane.
  always_ff @(posedge clk) begin
    if (!rst && state_q == CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else if (access_ok) begin
      for (int unsigned i = 0; i < NUM_BE; i++) begin
        if (en[1] && we[1][i]) mem_q[add[1]][8*i +: 8] <= din[1][8*i +: 8];
        if (en[0] && we[0][i]) mem_q[add[0]][8*i +: 8] <= din[0][8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < 2; p++) begin
        dout1_q[p]  <= '0;
        valid1_q[p] <= 1'b0;
        dout2_q[p]  <= '0;
        valid2_q[p] <= 1'b0;
      end
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        valid1_q[p] <= 1'b0;
        if (!busy_q && en[p]) begin
          if (we[p] == '0) begin
            dout1_q[p]  <= old_w[p];
            valid1_q[p] <= 1'b1;
          end else if (RDW_MODE == 0) begin
            dout1_q[p]  <= merged_w[p];
            valid1_q[p] <= 1'b1;
          end else if (RDW_MODE == 1) begin
            dout1_q[p]  <= old_w[p];
            valid1_q[p] <= 1'b1;
          end
        end
        dout2_q[p]  <= dout1_q[p];
        valid2_q[p] <= valid1_q[p];
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.a_dout  = (OUT_REG != 0) ? dout2_q[0]  : dout1_q[0];
  assign bus.a_valid = (OUT_REG != 0) ? valid2_q[0] : valid1_q[0];
  assign bus.b_dout  = (OUT_REG != 0) ? dout2_q[1]  : dout1_q[1];
  assign bus.b_valid = (OUT_REG != 0) ? valid2_q[1] : valid1_q[1];
endmodule

// File: tb/tb_memory_dp_be.sv
// Directed bench: four instances (WRITE_FIRST, READ_FIRST, NO_CHANGE, OUT_REG=1)
// share one stimulus stream and are each checked against hand-computed values.
module tb_memory_dp_be;
  logic        clk;
  logic        rst;
  logic        a_en, b_en;
  logic [3:0]  a_we, b_we;
  logic [3:0]  a_add, b_add;
  logic [31:0] a_din, b_din;

  logic        busy_o    [4];
  logic [31:0] a_dout_o  [4];
  logic        a_valid_o [4];
  logic [31:0] b_dout_o  [4];
  logic        b_valid_o [4];

  int checks = 0;
  int errors = 0;

  memory_dp_be_if #(.ADD_WIDTH(4), .DAT_WIDTH(32)) ifs [4] ();

  genvar g;
  for (g = 0; g < 4; g++) begin : g_dut
    assign ifs[g].a_en  = a_en;
    assign ifs[g].a_we  = a_we;
    assign ifs[g].a_add = a_add;
    assign ifs[g].a_din = a_din;
    assign ifs[g].b_en  = b_en;
    assign ifs[g].b_we  = b_we;
    assign ifs[g].b_add = b_add;
    assign ifs[g].b_din = b_din;

    memory_dp_be #(
      .ADD_WIDTH(4),
      .DAT_WIDTH(32),
      .RDW_MODE ((g < 3) ? g : 0),
      .OUT_REG  ((g == 3) ? 1 : 0)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(ifs[g])
    );

    assign busy_o[g]    = ifs[g].busy;
    assign a_dout_o[g]  = ifs[g].a_dout;
    assign a_valid_o[g] = ifs[g].a_valid;
    assign b_dout_o[g]  = ifs[g].b_dout;
    assign b_valid_o[g] = ifs[g].b_valid;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus at the falling edge, then sample 1 ns past the rising edge.
  task automatic drive(input logic ae, input logic [3:0] awe, input logic [3:0] aadd,
                       input logic [31:0] adin, input logic be, input logic [3:0] bwe,
                       input logic [3:0] badd, input logic [31:0] bdin);
    @(negedge clk);
    a_en = ae; a_we = awe; a_add = aadd; a_din = adin;
    b_en = be; b_we = bwe; b_add = badd; b_din = bdin;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic count_busy(input string name);
    int cnt;
    logic vseen;
    cnt = 1;
    vseen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (busy_o[0] !== 1'b1) break;
      cnt++;
      vseen = vseen | a_valid_o[0] | b_valid_o[0];
    end
    checks++;
    if (cnt != 16) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected 16", name, cnt);
    end
    checks++;
    if (vseen !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_during_busy: got %b expected 0", name, vseen);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a_en = 1'b1; a_we = 4'hF; a_add = 4'd2; a_din = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy_o[i] !== 1'b1 || a_valid_o[i] !== 1'b0 || b_valid_o[i] !== 1'b0 ||
          a_dout_o[i] !== 32'h0 || b_dout_o[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got busy=%b av=%b bv=%b ad=%h bd=%h expected 1 0 0 0 0",
                 i, busy_o[i], a_valid_o[i], b_valid_o[i], a_dout_o[i], b_dout_o[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    count_busy("reset");
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'h0, 4'(i), 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
      checks++;
      if (a_dout_o[0] !== 32'h0 || a_valid_o[0] !== 1'b1) begin
        errors++;
        $display("FAIL clear_read[%0d]: got %h/%b expected 00000000/1", i, a_dout_o[0], a_valid_o[0]);
      end
    end
    idle();
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 4'hF, 4'd5, 32'h1122_3344, 1'b0, 4'h0, 4'h0, 32'h0);
    drive(1'b1, 4'h5, 4'd5, 32'hAABB_CCDD, 1'b0, 4'h0, 4'h0, 32'h0);
    checks++;
    if (a_dout_o[0] !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL be_write_first: got %h expected 11bb33dd", a_dout_o[0]);
    end
    checks++;
    if (a_dout_o[1] !== 32'h1122_3344) begin
      errors++;
      $display("FAIL be_read_first: got %h expected 11223344", a_dout_o[1]);
    end
    drive(1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    checks++;
    if (a_dout_o[0] !== 32'h11BB_33DD || a_valid_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL be_read_a: got %h/%b expected 11bb33dd/1", a_dout_o[0], a_valid_o[0]);
    end
    checks++;
    if (b_dout_o[0] !== 32'h11BB_33DD || b_valid_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL be_read_b: got %h/%b expected 11bb33dd/1", b_dout_o[0], b_valid_o[0]);
    end
  endtask

  task automatic test_rdw_modes();
    drive(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'h0, 4'h0, 32'h0);
    checks++;
    if (a_dout_o[0] !== 32'hDEAD_BEEF || a_valid_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL rdw_mode0: got %h/%b expected deadbeef/1", a_dout_o[0], a_valid_o[0]);
    end
    checks++;
    if (a_dout_o[1] !== 32'h0 || a_valid_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL rdw_mode1: got %h/%b expected 00000000/1", a_dout_o[1], a_valid_o[1]);
    end
    checks++;
    if (a_dout_o[2] !== 32'h11BB_33DD || a_valid_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL rdw_mode2: got %h/%b expected 11bb33dd/0", a_dout_o[2], a_valid_o[2]);
    end
    drive(1'b1, 4'h3, 4'd3, 32'h0000_1111, 1'b0, 4'h0, 4'h0, 32'h0);
    checks++;
    if (a_dout_o[0] !== 32'hDEAD_1111 || a_dout_o[1] !== 32'hDEAD_BEEF || a_dout_o[2] !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL rdw_partial: got %h %h %h expected dead1111 deadbeef 11bb33dd",
               a_dout_o[0], a_dout_o[1], a_dout_o[2]);
    end
    drive(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    checks++;
    if (a_dout_o[2] !== 32'hDEAD_1111 || a_valid_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL rdw_mode2_read: got %h/%b expected dead1111/1", a_dout_o[2], a_valid_o[2]);
    end
    idle();
    checks++;
    if (a_dout_o[0] !== 32'hDEAD_1111 || a_valid_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL en_low_hold: got %h/%b expected dead1111/0", a_dout_o[0], a_valid_o[0]);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 4'h1, 4'd7, 32'h0000_00AA, 1'b1, 4'h3, 4'd7, 32'h0000_BBBB);
    drive(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    checks++;
    if (a_dout_o[0] !== 32'h0000_BBAA) begin
      errors++;
      $display("FAIL coll_ww: got %h expected 0000bbaa", a_dout_o[0]);
    end
    drive(1'b1, 4'hF, 4'd7, 32'h1234_5678, 1'b1, 4'h0, 4'd7, 32'h0);
    checks++;
    if (b_dout_o[0] !== 32'h0000_BBAA || b_dout_o[1] !== 32'h0000_BBAA || b_valid_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL coll_wr: got %h %h/%b expected 0000bbaa 0000bbaa/1",
               b_dout_o[0], b_dout_o[1], b_valid_o[0]);
    end
    checks++;
    if (a_dout_o[0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL coll_wr_a: got %h expected 12345678", a_dout_o[0]);
    end
    drive(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
    checks++;
    if (a_dout_o[0] !== 32'h1234_5678 || b_dout_o[0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL coll_rr: got %h %h expected 12345678 12345678", a_dout_o[0], b_dout_o[0]);
    end
    idle();
  endtask

  task automatic test_out_reg();
    drive(1'b1, 4'hF, 4'd1, 32'h1, 1'b0, 4'h0, 4'h0, 32'h0);
    drive(1'b1, 4'hF, 4'd2, 32'h2, 1'b0, 4'h0, 4'h0, 32'h0);
    drive(1'b1, 4'hF, 4'd3, 32'h3, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    idle();
    drive(1'b1, 4'h0, 4'd1, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    checks++;
    if (a_valid_o[3] !== 1'b0 || a_dout_o[0] !== 32'h1) begin
      errors++;
      $display("FAIL oreg_lat1: got v3=%b d0=%h expected 0 00000001", a_valid_o[3], a_dout_o[0]);
    end
    drive(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    checks++;
    if (a_valid_o[3] !== 1'b1 || a_dout_o[3] !== 32'h1) begin
      errors++;
      $display("FAIL oreg_d1: got %h/%b expected 00000001/1", a_dout_o[3], a_valid_o[3]);
    end
    drive(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    checks++;
    if (a_valid_o[3] !== 1'b1 || a_dout_o[3] !== 32'h2) begin
      errors++;
      $display("FAIL oreg_d2: got %h/%b expected 00000002/1", a_dout_o[3], a_valid_o[3]);
    end
    idle();
    checks++;
    if (a_valid_o[3] !== 1'b1 || a_dout_o[3] !== 32'h3) begin
      errors++;
      $display("FAIL oreg_d3: got %h/%b expected 00000003/1", a_dout_o[3], a_valid_o[3]);
    end
    idle();
    checks++;
    if (a_valid_o[3] !== 1'b0 || a_dout_o[3] !== 32'h3) begin
      errors++;
      $display("FAIL oreg_end: got %h/%b expected 00000003/0", a_dout_o[3], a_valid_o[3]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (busy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear_busy: got %b expected 1", busy_o[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    count_busy("mid_clear");

    drive(1'b1, 4'hF, 4'd10, 32'hA0A0_A0A0, 1'b0, 4'h0, 4'h0, 32'h0);
    drive(1'b1, 4'hF, 4'd11, 32'hB1B1_B1B1, 1'b0, 4'h0, 4'h0, 32'h0);
    checks++;
    if (a_dout_o[0] !== 32'hB1B1_B1B1) begin
      errors++;
      $display("FAIL burst_write: got %h expected b1b1b1b1", a_dout_o[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    a_en = 1'b1; a_we = 4'hF; a_add = 4'd12; a_din = 32'hCAFE_F00D;
    b_en = 1'b1; b_we = 4'hF; b_add = 4'd13; b_din = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    checks++;
    if (busy_o[0] !== 1'b1 || a_dout_o[0] !== 32'h0 || a_valid_o[0] !== 1'b0 || b_dout_o[0] !== 32'h0) begin
      errors++;
      $display("FAIL burst_reset: got busy=%b ad=%h av=%b bd=%h expected 1 0 0 0",
               busy_o[0], a_dout_o[0], a_valid_o[0], b_dout_o[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    a_en = 1'b0; a_we = 4'h0; b_en = 1'b0; b_we = 4'h0;
    count_busy("burst_clear");
    drive(1'b1, 4'h0, 4'd12, 32'h0, 1'b1, 4'h0, 4'd10, 32'h0);
    checks++;
    if (a_dout_o[0] !== 32'h0 || a_valid_o[0] !== 1'b1 || b_dout_o[0] !== 32'h0 || b_valid_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_read: got %h/%b %h/%b expected 0/1 0/1",
               a_dout_o[0], a_valid_o[0], b_dout_o[0], b_valid_o[0]);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    a_en = 1'b0; a_we = 4'h0; a_add = 4'h0; a_din = 32'h0;
    b_en = 1'b0; b_we = 4'h0; b_add = 4'h0; b_din = 32'h0;
    test_reset();
    test_byte_enable();
    test_rdw_modes();
    test_collision();
    test_out_reg();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_dp_be.md
Name: memory_dp_be

Overview:
- Dual-port synchronous RAM with byte-lane write enables, selectable read-during-write mode and an optional output pipeline stage.
- Includes a built-in clear engine that zero-fills the whole array after reset.
- Drop-in storage for the buffers and register files in later sessions; replaces the single-port en/we memory wherever two agents share one array.

Parameters:
- ADD_WIDTH, 10, address width; DEPTH = 1<<ADD_WIDTH words.
- DAT_WIDTH, 32, data width; must be a multiple of 8.
- NUM_BE, DAT_WIDTH/8, byte lanes per word (derived, not overridable).
- RDW_MODE, 0, same-port read-during-write: 0=WRITE_FIRST (dout = merged new word), 1=READ_FIRST (dout = old word), 2=NO_CHANGE (dout holds).
- OUT_REG, 0, 0: read latency 1 cycle; 1: extra output register, latency 2 cycles.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- busy  output  1  high while the clear engine runs; ports are ignored.
- a_en  input  1  port A access enable.
- a_we  input  NUM_BE  port A byte write enables; all zero = read.
- a_add  input  ADD_WIDTH  port A address.
- a_din  input  DAT_WIDTH  port A write data.
- a_dout  output  DAT_WIDTH  port A read data.
- a_valid  output  1  a_dout updated this cycle.
- b_en, b_we, b_add, b_din, b_dout, b_valid  same as port A, for port B.

Behaviour:
- Reset (rst=1 at an edge):
  - a_dout=b_dout=0, a_valid=b_valid=0, pipeline registers cleared, busy=1, clear pointer=0.
  - Reset asserted mid-clear restarts the clear from address 0.
- Clear engine FSM, states IDLE and CLEAR:
  - Reset forces CLEAR.
  - In CLEAR: writes 0 to mem[ptr] each cycle, ptr increments; after writing DEPTH-1, next state IDLE and busy=0 on the following edge.
  - Clear takes exactly DEPTH cycles after rst deasserts.
  - In IDLE: no activity.
- While busy=1:
  - en/we on both ports are ignored: no writes, valid stays 0, dout holds 0.
- Access, per port p, when busy=0 and p_en=1:
  - Byte lane i of mem[p_add] takes p_din[8i+7:8i] where p_we[i]=1; other lanes are unchanged.
  - p_we all zero: pure read of mem[p_add].
  - With any p_we bit set, dout follows RDW_MODE:
    - WRITE_FIRST: dout = merged word (old lanes kept, written lanes new).
    - READ_FIRST: dout = pre-write word.
    - NO_CHANGE: dout and valid unchanged.
  - OUT_REG=0: dout/valid register at the access edge (visible next cycle).
  - OUT_REG=1: one more register stage; valid pulses exactly two edges after the access.
  - p_en=0: dout holds its last value, valid=0 next cycle.
- Cross-port rules, same address in the same cycle:
  - Both write: per byte lane, A's data wins where both p_we[i]=1; lanes written by only one port take that port's data.
  - One writes, the other reads: the reader returns the old word (READ_FIRST across ports regardless of RDW_MODE).
  - Both read: both return the same word.
- Throughput: one access per port per cycle, back-to-back, no stalls outside busy.
- Simulation only: delay-free NBAs; no X on dout after reset.

Test Plan:
- Clear after reset: pulse rst 1 cycle with ADD_WIDTH=4 -> busy high exactly 16 cycles; then reading all 16 addresses returns 0x00000000 with a_valid 1 cycle after each access.
- Byte enables: write 0x11223344 to addr 5 with a_we=4'b1111, then 0xAABBCCDD with a_we=4'b0101 -> read addr 5 returns 0x11BB33DD.
- RDW modes: addr 3 holds 0x0; write 0xDEADBEEF, full we -> a_dout = 0xDEADBEEF (mode 0), 0x00000000 (mode 1), previous a_dout unchanged with a_valid=0 (mode 2).
- Collision: same cycle A writes 0x000000AA (we=0001) and B writes 0x0000BBBB (we=0011) to addr 7 -> mem[7]=0x0000BBAA; simultaneous B read of addr 7 while A writes 0x12345678 -> b_dout = old word.
- OUT_REG=1: back-to-back reads of addr 1,2,3 preloaded 0x1,0x2,0x3 -> a_valid high for 3 consecutive cycles starting 2 edges after the first access; data 0x1,0x2,0x3 in order.
- Reset mid-operation: assert rst at clear pointer 9, and separately during a write burst -> busy restarts, pointer back to 0, outputs 0; a write issued in the same cycle as rst is not committed (reads 0 after clear).
